fft_frame_ctrl: RTL and testbench

Frame sequencer in front of `fft_top` in the user-domain FFT accelerator. Accepts a software-issued job of `num_frames_i` frames, admits exactly N = 2^LOGN source samples per frame into the FFT, and counts N bit-reversed results out per frame. It then advances to the next frame or signals completion. Provides `busy_o`, a one-cycle `done_o` pulse, and abort handling; the FFT datapath itself stays free of control state.

---
 rtl/fft_pkg.sv | 15 +
 rtl/user_pkg.sv | 11 +
 rtl/fft_frame_cnt.sv | 32 +++
 rtl/fft_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// FFT controller types: sequencer state enum and frame-length helper.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } fft_ctrl_state_e;

  function automatic int unsigned fft_frame_len(input int unsigned logn);
    return 32'd1 << logn;
  endfunction

endpackage

// File: rtl/user_pkg.sv
// Shared user-domain stream type: a valid flag with a data word.
package user_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } strm_t;

endpackage

// File: rtl/fft_frame_cnt.sv
// LOGN+1-bit frame sample counter; hit_n flags the increment that reaches N.
module fft_frame_cnt
  import fft_pkg::*;
#(
  parameter int unsigned LOGN = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit_n
);

  localparam int unsigned   N    = fft_frame_len(LOGN);
  localparam logic [LOGN:0] LAST = (LOGN + 1)'(N - 1);

  logic [LOGN:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + (LOGN + 1)'(1);
    end
  end

  // Combinational so the FSM can leave LOAD/DRAIN on the very edge of the N-th transfer.
  assign hit_n = en && (count == LAST);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of fft_top: admits N samples per frame, counts N results out.
// Optional drain watchdog enabled with `define FFT_FRAME_CTRL_TIMEOUT_EN.
module fft_frame_ctrl
  import user_pkg::*;
  import fft_pkg::*;
#(
  parameter int unsigned LOGN    = 10,
  parameter int unsigned FRAME_W = 16
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [FRAME_W-1:0] num_frames_i,
  input  strm_t              src_i,
  output logic               src_ready_o,
  output strm_t              fft_in_o,
  input  strm_t              fft_out_i,
  output logic               fft_ready_o,
  output strm_t              dst_o,
  input  logic               dst_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [FRAME_W-1:0] frame_idx_o,
  output logic               err_o
);

  fft_ctrl_state_e    state, state_next;
  logic [FRAME_W-1:0] num_frames_q, frame_idx_q;
  strm_t              fft_in_q;
  logic               start_acc, in_en, out_en, in_hit, out_hit;
  logic               more_frames, timeout, cnt_clr;

  assign start_acc   = (state == IDLE) && start_i && !abort_i;
  assign src_ready_o = (state == LOAD);
  assign in_en       = src_ready_o && src_i.valid;
  assign out_en      = (state == DRAIN) && fft_out_i.valid && dst_ready_i;
  assign more_frames = ({1'b0, frame_idx_q} + (FRAME_W + 1)'(1)) < {1'b0, num_frames_q};
  assign cnt_clr     = abort_i || start_acc || out_hit || timeout;

  fft_frame_cnt #(.LOGN(LOGN)) u_in_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (cnt_clr),
    .en    (in_en),
    .hit_n (in_hit)
  );

  fft_frame_cnt #(.LOGN(LOGN)) u_out_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (cnt_clr),
    .en    (out_en),
    .hit_n (out_hit)
  );

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // Watchdog counts consecutive DRAIN cycles without a counted result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state != DRAIN) || out_en || abort_i) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (start_acc) begin
        err_q <= 1'b0;
      end else if (timeout && !abort_i) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout = (state == DRAIN) && !out_en && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_acc) state_next = LOAD;
      LOAD:    if (in_hit) state_next = DRAIN;
      DRAIN: begin
        if (timeout) begin
          state_next = IDLE;
        end else if (out_hit) begin
          state_next = more_frames ? LOAD : DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      num_frames_q <= '0;
      frame_idx_q  <= '0;
      fft_in_q     <= '0;
    end else begin
      state <= state_next;
      if (start_acc) begin
        num_frames_q <= (num_frames_i == '0) ? FRAME_W'(1) : num_frames_i;
      end
      if (abort_i || start_acc || timeout) begin
        frame_idx_q <= '0;
      end else if (out_hit && more_frames) begin
        frame_idx_q <= frame_idx_q + FRAME_W'(1);
      end
      // Abort drops the feed valid on the same edge; data is left as-is.
      fft_in_q.valid <= in_en && !abort_i;
      if (in_en && !abort_i) begin
        fft_in_q.data <= src_i.data;
      end
    end
  end

  assign fft_in_o    = fft_in_q;
  assign dst_o       = fft_out_i;
  assign fft_ready_o = dst_ready_i;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign frame_idx_o = frame_idx_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl at LOGN=3: table-driven jobs with random
// handshakes against a job-level reference model, plus abort/priority/timeout sequences.
module tb_fft_frame_ctrl;
  import user_pkg::*;

  localparam int LOGN    = 3;
  localparam int N       = 8;
  localparam int FRAME_W = 16;
  localparam int TMO     = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               dst_ready = 1'b0;
  logic [FRAME_W-1:0] num_frames = '0;
  strm_t              src = '0;
  strm_t              fft_out = '0;
  strm_t              fft_in, dst;
  logic               src_ready, fft_ready, busy, done, err;
  logic [FRAME_W-1:0] frame_idx;

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .LOGN    (LOGN),
    .FRAME_W (FRAME_W)
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TMO)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .num_frames_i (num_frames),
    .src_i        (src),
    .src_ready_o  (src_ready),
    .fft_in_o     (fft_in),
    .fft_out_i    (fft_out),
    .fft_ready_o  (fft_ready),
    .dst_o        (dst),
    .dst_ready_i  (dst_ready),
    .busy_o       (busy),
    .done_o       (done),
    .frame_idx_o  (frame_idx),
    .err_o        (err)
  );

  typedef enum {M_IDLE, M_LOAD, M_DRAIN, M_DONE} mphase_t;

  typedef struct {
    int frames;
    int src_pct;
    int dst_pct;
    int exp_in;
    int exp_out;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Job-level reference: what the job should look like after each edge.
  mphase_t     ph = M_IDLE;
  int          in_n = 0, out_n = 0, frame = 0, frames_eff = 1, stall = 0;
  logic        exp_in_v = 1'b0;
  logic [31:0] exp_in_d = '0;
  logic        exp_err = 1'b0;

  // Behavioural stand-in for fft_top: collect a full frame, emit it bit-reversed.
  logic [31:0] inq[$];
  logic [31:0] outq[$];
  int          fv_pct = 90;

  int obs_in = 0, obs_out = 0, obs_done = 0;

  function automatic int brev(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic sv, input logic [31:0] sd, input logic st,
                                input logic ab, input logic dr);
    logic hs_out;
    @(negedge clk);
    src.valid     = sv;
    src.data      = sd;
    start         = st;
    abort         = ab;
    dst_ready     = dr;
    fft_out.valid = (outq.size() > 0) && ($urandom_range(99) < fv_pct);
    fft_out.data  = (outq.size() > 0) ? outq[0] : 32'h0;
    #1;
    check_output("src_ready", src_ready, ph == M_LOAD);
    check_output("dst_pass", {dst.valid, dst.data}, {fft_out.valid, fft_out.data});
    check_output("fft_ready", fft_ready, dr);

    if (fft_out.valid && dr) begin
      void'(outq.pop_front());
      obs_out++;
    end

    hs_out   = (ph == M_DRAIN) && fft_out.valid && dr;
    exp_in_v = 1'b0;
    if (ab) begin
      ph    = M_IDLE;
      in_n  = 0;
      out_n = 0;
      frame = 0;
      stall = 0;
      inq.delete();
    end else begin
      case (ph)
        M_IDLE: if (st) begin
          ph         = M_LOAD;
          frames_eff = (num_frames == 0) ? 1 : int'(num_frames);
          frame      = 0;
          in_n       = 0;
          out_n      = 0;
          exp_err    = 1'b0;
        end
        M_LOAD: begin
          exp_in_v = sv;
          if (sv) begin
            exp_in_d = sd;
            in_n++;
            if (in_n == N) begin
              ph    = M_DRAIN;
              stall = 0;
            end
          end
        end
        M_DRAIN: begin
          if (hs_out) begin
            stall = 0;
            out_n++;
            if (out_n == N) begin
              if (frame + 1 < frames_eff) begin
                frame++;
                in_n  = 0;
                out_n = 0;
                ph    = M_LOAD;
              end else begin
                ph = M_DONE;
              end
            end
          end else begin
            stall++;
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
            if (stall == TMO) begin
              exp_err = 1'b1;
              ph      = M_IDLE;
              frame   = 0;
              in_n    = 0;
              out_n   = 0;
              stall   = 0;
            end
`endif
          end
        end
        M_DONE: ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end

    @(posedge clk);
    #1;
    check_output("fft_in_valid", fft_in.valid, exp_in_v);
    if (exp_in_v) check_output("fft_in_data", fft_in.data, exp_in_d);
    check_output("busy", busy, ph != M_IDLE);
    check_output("done", done, ph == M_DONE);
    check_output("frame_idx", frame_idx, frame);
    check_output("err", err, exp_err);

    if (fft_in.valid) begin
      obs_in++;
      inq.push_back(fft_in.data);
      if (inq.size() == N) begin
        for (int i = 0; i < N; i++) outq.push_back(inq[brev(i)]);
        inq.delete();
      end
    end
    if (done) obs_done++;
  endtask

  task automatic finish_job(input int src_pct, input int dst_pct);
    int budget = 0;
    while (ph != M_IDLE && budget < 3000) begin
      apply_stimulus($urandom_range(99) < src_pct, $urandom, 1'b0, 1'b0,
                     $urandom_range(99) < dst_pct);
      budget++;
    end
    if (ph != M_IDLE) begin
      checks++;
      errors++;
      $display("[TB] FAIL job_timeout: got still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic run_job(input int frames, input int src_pct, input int dst_pct,
                         input int exp_in, input int exp_out);
    obs_in     = 0;
    obs_out    = 0;
    obs_done   = 0;
    num_frames = FRAME_W'(frames);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    finish_job(src_pct, dst_pct);
    check_output("job_inputs", obs_in, exp_in);
    check_output("job_results", obs_out, exp_out);
    check_output("job_dones", obs_done, 1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{frames: 1, src_pct: 100, dst_pct: 100, exp_in: 8,  exp_out: 8};
    vecs[1] = '{frames: 3, src_pct: 100, dst_pct: 100, exp_in: 24, exp_out: 24};
    vecs[2] = '{frames: 1, src_pct: 100, dst_pct: 50,  exp_in: 8,  exp_out: 8};
    vecs[3] = '{frames: 0, src_pct: 70,  dst_pct: 80,  exp_in: 8,  exp_out: 8};
    vecs[4] = '{frames: 2, src_pct: 60,  dst_pct: 60,  exp_in: 16, exp_out: 16};
    vecs[5] = '{frames: 4, src_pct: 50,  dst_pct: 90,  exp_in: 32, exp_out: 32};
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    fv_pct = 100;
`endif

    #1 rst_n = 1'b0;
    #10;
    check_output("rst_fft_in", fft_in, 33'h0);
    check_output("rst_src_ready", src_ready, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_err", err, 1'b0);
    check_output("rst_frame_idx", frame_idx, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v].frames, vecs[v].src_pct, vecs[v].dst_pct,
              vecs[v].exp_in, vecs[v].exp_out);
    end

    // Abort part-way through loading, then a clean frame.
    obs_done   = 0;
    num_frames = 16'd1;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
    check_output("abort_src_ready", src_ready, 1'b0);
    check_output("abort_busy", busy, 1'b0);
    repeat (3) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_output("abort_no_done", obs_done, 0);
    run_job(1, 100, 100, 8, 8);

    // Abort together with start in IDLE: stays idle.
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check_output("abort_start_busy", busy, 1'b0);

    // Start while loading is ignored.
    obs_in   = 0;
    obs_done = 0;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
    finish_job(100, 100);
    check_output("restart_inputs", obs_in, 8);
    check_output("restart_dones", obs_done, 1);

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    obs_done = 0;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) apply_stimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    repeat (TMO) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("tmo_err", err, 1'b1);
    check_output("tmo_busy", busy, 1'b0);
    check_output("tmo_no_done", obs_done, 0);
    outq.delete();
    run_job(1, 100, 100, 8, 8);
    check_output("tmo_err_cleared", err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
